// File: rtl/decrypt_iter.sv
// Iterative decryptor for the 64-bit, 10-round nibble SPN cipher.
// Runs one inverse round per clock between an input and an output valid/ready handshake.
module decrypt_iter #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] secretKey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext
);

  localparam int unsigned W  = 64;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  st, st_n, rk, rk_n, pt_n, rnd;
  logic [CW-1:0] cnt, cnt_n;

  function automatic logic [3:0] inv_sb_nib(input logic [3:0] x);
    case (x)
      4'h0: inv_sb_nib = 4'h2;  4'h1: inv_sb_nib = 4'hE;
      4'h2: inv_sb_nib = 4'h9;  4'h3: inv_sb_nib = 4'h5;
      4'h4: inv_sb_nib = 4'h3;  4'h5: inv_sb_nib = 4'hC;
      4'h6: inv_sb_nib = 4'h0;  4'h7: inv_sb_nib = 4'hA;
      4'h8: inv_sb_nib = 4'h7;  4'h9: inv_sb_nib = 4'hF;
      4'hA: inv_sb_nib = 4'h8;  4'hB: inv_sb_nib = 4'h1;
      4'hC: inv_sb_nib = 4'hB;  4'hD: inv_sb_nib = 4'h4;
      4'hE: inv_sb_nib = 4'hD;  default: inv_sb_nib = 4'h6;
    endcase
  endfunction

  function automatic logic [W-1:0] inv_sb(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sb_nib(x[4*i +: 4]);
    return y;
  endfunction

  // Row r (row 0 in the top 16 bits) is rotated right by 4r bits.
  function automatic logic [W-1:0] inv_sr(input logic [W-1:0] x);
    return {x[63:48],
            x[35:32], x[47:36],
            x[23:16], x[31:24],
            x[11:0],  x[15:12]};
  endfunction

  function automatic logic [W-1:0] rotr4(input logic [W-1:0] x);
    return {x[3:0], x[63:4]};
  endfunction

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    st_n    = st;
    rk_n    = rk;
    cnt_n   = cnt;
    pt_n    = plaintext;
    rnd     = inv_sb(inv_sr(st ^ rk));
    case (state)
      IDLE: begin
        if (in_valid) begin
          st_n    = ciphertext;
          rk_n    = {secretKey[23:0], secretKey[63:24]};
          cnt_n   = '0;
          state_n = ROUND;
        end
      end
      ROUND: begin
        st_n = rnd;
        rk_n = rotr4(rk);
        if (cnt == LAST) begin
          pt_n    = rnd ^ rotr4(rk);
          state_n = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      st        <= '0;
      rk        <= '0;
      cnt       <= '0;
      plaintext <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      st        <= st_n;
      rk        <= rk_n;
      cnt       <= cnt_n;
      plaintext <= pt_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

endmodule
